rt_status_mbox: RTL and testbench

- OBI slave peripheral on the RT crossbar. Gives target software a channel back to the host debugger.
- Software writes an exit code. The block latches it in {done, code} form, which the JTAG host polls for end-of-computation.
- Also buffers putchar bytes for a host-side console stream, exposes a 64-bit cycle counter, and runs a programmable watchdog that forces a failing exit.

---
 rtl/rt_status_mbox_pkg.sv | 18 +
 rtl/rt_status_char_fifo.sv | 50 +++++
 rtl/rt_status_mbox.sv | 150 +++++++++++++++
 tb/tb_rt_status_mbox.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_status_mbox_pkg.sv
// Shared definitions for the RT status mailbox: register offsets, exit record
// layout and the code forced by a watchdog expiry.
package rt_status_mbox_pkg;

    localparam logic [4:0] ExitOffs  = 5'h00;
    localparam logic [4:0] PutcOffs  = 5'h04;
    localparam logic [4:0] CycLoOffs = 5'h08;
    localparam logic [4:0] CycHiOffs = 5'h0C;
    localparam logic [4:0] WdogOffs  = 5'h10;

    localparam logic [30:0] WdogExitCode = 31'h7FFF_FFFF;

    typedef struct packed {
        logic        done;
        logic [30:0] code;
    } exit_reg_t;

endpackage

// File: rtl/rt_status_char_fifo.sv
// 8-bit show-ahead FIFO for console bytes. Pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module rt_status_char_fifo #(
    parameter int Depth = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level
);

    localparam int PtrW = $clog2(Depth);

    logic [7:0]    mem [Depth];
    logic [PtrW:0] wr_ptr;
    logic [PtrW:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                     (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[PtrW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PtrW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rt_status_mbox.sv
// OBI status mailbox: exit code latch, console byte FIFO, 64-bit cycle counter
// with read-snapshot of the upper half, and a watchdog that forces a failing exit.
module rt_status_mbox
    import rt_status_mbox_pkg::*;
#(
    parameter int          FifoDepth    = 16,
    parameter logic [31:0] WdogResetVal = 32'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        obi_req_i,
    output logic        obi_gnt_o,
    input  logic [31:0] obi_addr_i,
    input  logic        obi_we_i,
    input  logic [3:0]  obi_be_i,
    input  logic [31:0] obi_wdata_i,
    output logic        obi_rvalid_o,
    output logic [31:0] obi_rdata_o,
    output logic        obi_err_o,
    output logic        char_valid_o,
    input  logic        char_ready_i,
    output logic [7:0]  char_data_o,
    output logic        eoc_o,
    output logic [30:0] exit_code_o,
    output logic        wdog_fired_o
);

    logic [4:0]  offs;
    logic        mapped;
    logic        push_req;
    logic        pop;
    logic        access;
    logic        wr;
    logic        exit_wr;
    logic        wdog_wr;
    logic        cyc_lo_rd;
    logic        wdog_expire;

    logic        fifo_full;
    logic        fifo_empty;
    logic [$clog2(FifoDepth):0] fifo_level;

    exit_reg_t   exit_reg;
    logic        fired;
    logic [31:0] wdog_cnt;
    logic [63:0] cycle_cnt;
    logic [31:0] cyc_hi_shadow;

    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] rdata_next;
    logic        err_next;

    logic        unused_bits;
    assign unused_bits = ^{obi_addr_i[31:5], obi_addr_i[1:0], obi_be_i[3:1]};

    assign offs     = {obi_addr_i[4:2], 2'b00};
    assign mapped   = (offs <= WdogOffs);
    assign push_req = obi_req_i && obi_we_i && (offs == PutcOffs) && obi_be_i[0];
    assign pop      = char_valid_o && char_ready_i;

    // Only a byte push into a full FIFO with no simultaneous pop is stalled.
    assign obi_gnt_o = obi_req_i && !(push_req && fifo_full && !pop);
    assign access    = obi_req_i && obi_gnt_o;
    assign wr        = access && obi_we_i;
    assign exit_wr   = wr && (offs == ExitOffs);
    assign wdog_wr   = wr && (offs == WdogOffs);
    assign cyc_lo_rd = access && !obi_we_i && (offs == CycLoOffs);

    // A WDOG write on the expiry cycle reloads the counter instead of firing.
    assign wdog_expire = (wdog_cnt == 32'd1) && !exit_reg.done && !wdog_wr;

    rt_status_char_fifo #(
        .Depth (FifoDepth)
    ) u_char_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push_req && obi_gnt_o),
        .push_data (obi_wdata_i[7:0]),
        .pop       (pop),
        .head      (char_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign char_valid_o = !fifo_empty;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        rdata_next = '0;
        err_next   = 1'b0;
        if (!mapped) begin
            err_next = 1'b1;
        end else if (!obi_we_i) begin
            case (offs)
                ExitOffs:  rdata_next = exit_reg;
                PutcOffs:  rdata_next = 32'(fifo_level);
                CycLoOffs: rdata_next = cycle_cnt[31:0];
                CycHiOffs: rdata_next = cyc_hi_shadow;
                WdogOffs:  rdata_next = wdog_cnt;
                default:   rdata_next = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid        <= 1'b0;
            rdata         <= '0;
            err           <= 1'b0;
            exit_reg      <= '0;
            fired         <= 1'b0;
            wdog_cnt      <= WdogResetVal;
            cycle_cnt     <= '0;
            cyc_hi_shadow <= '0;
        end else begin
            rvalid    <= access;
            rdata     <= access ? rdata_next : '0;
            err       <= access && err_next;
            cycle_cnt <= cycle_cnt + 64'd1;

            if (cyc_lo_rd) cyc_hi_shadow <= cycle_cnt[63:32];

            // A software exit on the expiry cycle wins and suppresses the watchdog.
            if (exit_wr && !exit_reg.done) begin
                exit_reg <= '{done: 1'b1, code: obi_wdata_i[30:0]};
            end else if (wdog_expire) begin
                exit_reg <= '{done: 1'b1, code: WdogExitCode};
                fired    <= 1'b1;
            end

            if (wdog_wr) begin
                wdog_cnt <= obi_wdata_i;
            end else if (wdog_cnt != 32'd0 && !exit_reg.done) begin
                wdog_cnt <= wdog_cnt - 32'd1;
            end
        end
    end

    assign obi_rvalid_o = rvalid;
    assign obi_rdata_o  = rdata;
    assign obi_err_o    = err;
    assign eoc_o        = exit_reg.done;
    assign exit_code_o  = exit_reg.code;
    assign wdog_fired_o = fired;

endmodule

// File: tb/tb_rt_status_mbox.sv
// Directed bench for rt_status_mbox: OBI responses and console bytes are
// predicted into scoreboard queues at drive time and compared on output.
module tb_rt_status_mbox;

    import rt_status_mbox_pkg::*;

    localparam logic [31:0] WdogResetVal = 32'd0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        char_valid;
    logic        char_ready;
    logic [7:0]  char_data;
    logic        eoc;
    logic [30:0] exit_code;
    logic        fired;

    resp_t      exp_q[$];
    logic [7:0] char_q[$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rt_status_mbox #(
        .FifoDepth    (16),
        .WdogResetVal (WdogResetVal)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .obi_req_i    (req),
        .obi_gnt_o    (gnt),
        .obi_addr_i   (addr),
        .obi_we_i     (we),
        .obi_be_i     (be),
        .obi_wdata_i  (wdata),
        .obi_rvalid_o (rvalid),
        .obi_rdata_o  (rdata),
        .obi_err_o    (err),
        .char_valid_o (char_valid),
        .char_ready_i (char_ready),
        .char_data_o  (char_data),
        .eoc_o        (eoc),
        .exit_code_o  (exit_code),
        .wdog_fired_o (fired)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic compare_resp(input string tag);
        resp_t r;
        check({tag, "_rvalid"}, rvalid, 1);
        r = exp_q.pop_front();
        check({tag, "_rdata"}, rdata, r.rdata);
        check({tag, "_err"}, err, r.err);
    endtask

    // One OBI transfer; consecutive calls land on consecutive clock edges.
    task automatic access(input string tag, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] b,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int waits;
        @(negedge clk);
        req = 1'b1; addr = a; we = w; wdata = d; be = b;
        #1;
        waits = 0;
        while (gnt !== 1'b1 && waits < 40) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (gnt !== 1'b1) begin
            checks++;
            failures++;
            $error("FAIL %s_gnt_timeout: observed gnt 0x%0h expected 0x1", tag, gnt);
            req = 1'b0;
            return;
        end
        exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        if (w && a[4:2] == 3'd1 && b[0]) char_q.push_back(d[7:0]);
        @(posedge clk);
        #1;
        req = 1'b0;
        compare_resp(tag);
    endtask

    initial begin
        logic [7:0] exp_byte;

        rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
        char_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rvalid", rvalid, 0);
        check("rst_gnt", gnt, 0);
        check("rst_char_valid", char_valid, 0);
        check("rst_eoc", eoc, 0);
        check("rst_exit_code", exit_code, 0);
        check("rst_fired", fired, 0);
        rst = 1'b0;

        access("rst_exit_rd", 32'h00, 0, 0, 4'hF, 32'h0, 0);
        access("rst_wdog_rd", 32'h10, 0, 0, 4'hF, WdogResetVal, 0);
        access("rst_level_rd", 32'h04, 0, 0, 4'hF, 32'h0, 0);

        // Unmapped window
        access("unm_rd18", 32'h18, 0, 0, 4'hF, 32'h0, 1);
        access("unm_wr1c", 32'h1C, 1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1);
        access("unm_wr14", 32'h14, 1, 32'h0000_0055, 4'hF, 32'h0, 1);
        access("unm_exit_rd", 32'h00, 0, 0, 4'hF, 32'h0, 0);
        access("unm_wdog_rd", 32'h10, 0, 0, 4'hF, 32'h0, 0);
        check("unm_eoc", eoc, 0);
        check("unm_char_valid", char_valid, 0);

        // PUTC with be[0]=0 is a no-op
        access("putc_noop", 32'h04, 1, 32'h99, 4'b1110, 32'h0, 0);
        access("noop_level", 32'h04, 0, 0, 4'hF, 32'h0, 0);

        // Fill to full with consumer stalled
        for (int i = 0; i < 16; i++) begin
            access("putc_fill", 32'h04, 1, 32'h41 + i, 4'hF, 32'h0, 0);
        end
        access("full_level", 32'h04, 0, 0, 4'hF, 32'd16, 0);

        @(negedge clk);
        req = 1'b1; addr = 32'h04; we = 1'b1; wdata = 32'h51; be = 4'hF;
        #1;
        check("full_gnt_low", gnt, 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("full_gnt_held", gnt, 0);
        end
        char_ready = 1'b1;
        #1;
        check("pop_gnt_same_cycle", gnt, 1);
        exp_q.push_back('{rdata: 32'h0, err: 1'b0});
        char_q.push_back(8'h51);
        exp_byte = char_q.pop_front();
        check("pop_first_byte", char_data, exp_byte);
        @(posedge clk);
        #1;
        req = 1'b0;
        char_ready = 1'b0;
        compare_resp("putc17");
        access("level_after_17", 32'h04, 0, 0, 4'hF, 32'd16, 0);

        char_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("drain_valid", char_valid, 1);
            exp_byte = char_q.pop_front();
            check("drain_byte", char_data, exp_byte);
        end
        @(posedge clk);
        #1;
        char_ready = 1'b0;
        check("drain_empty", char_valid, 0);
        check("idle_rvalid", rvalid, 0);

        // Cycle counter snapshot across the 32-bit wrap
        dut.cycle_cnt = 64'h0000_0000_FFFF_FFFE;
        access("cyc_lo", 32'h08, 0, 0, 4'hF, 32'hFFFF_FFFE, 0);
        repeat (2) @(posedge clk);
        access("cyc_hi_shadow", 32'h0C, 0, 0, 4'hF, 32'h0, 0);
        access("cyc_lo2", 32'h08, 0, 0, 4'hF, 32'h0000_0002, 0);
        access("cyc_hi2", 32'h0C, 0, 0, 4'hF, 32'h1, 0);
        access("cyc_wr_ignored", 32'h08, 1, 32'h1234, 4'hF, 32'h0, 0);

        // WDOG reload landing on the expiry edge prevents firing
        access("wd_ld3", 32'h10, 1, 32'd3, 4'hF, 32'h0, 0);
        repeat (2) @(posedge clk);
        access("wd_reload", 32'h10, 1, 32'd100, 4'hF, 32'h0, 0);
        check("reload_fired", fired, 0);
        check("reload_eoc", eoc, 0);
        access("wd_rd100", 32'h10, 0, 0, 4'hF, 32'd100, 0);
        access("wd_rd99", 32'h10, 0, 0, 4'hF, 32'd99, 0);
        access("wd_disable", 32'h10, 1, 32'd0, 4'hF, 32'h0, 0);
        access("wd_rd0", 32'h10, 0, 0, 4'hF, 32'd0, 0);

        // EXIT latch, first write wins
        access("exit_wr1", 32'h00, 1, 32'h0000_0001, 4'hF, 32'h0, 0);
        check("exit_eoc", eoc, 1);
        check("exit_code", exit_code, 1);
        access("exit_rd", 32'h00, 0, 0, 4'hF, 32'h8000_0001, 0);
        access("exit_wr0", 32'h00, 1, 32'h0, 4'hF, 32'h0, 0);
        access("exit_rd_again", 32'h00, 0, 0, 4'hF, 32'h8000_0001, 0);
        check("exit_code_kept", exit_code, 1);
        access("frz_ld", 32'h10, 1, 32'd7, 4'hF, 32'h0, 0);
        access("frz_rd1", 32'h10, 0, 0, 4'hF, 32'd7, 0);
        access("frz_rd2", 32'h10, 0, 0, 4'hF, 32'd7, 0);

        // Reset while a granted request is in flight and the FIFO holds data
        for (int i = 0; i < 3; i++) begin
            access("rst_fill", 32'h04, 1, 32'h61 + i, 4'hF, 32'h0, 0);
        end
        access("rst_fill_level", 32'h04, 0, 0, 4'hF, 32'd3, 0);
        @(negedge clk);
        req = 1'b1; addr = 32'h00; we = 1'b0; be = 4'hF;
        rst = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_char_valid", char_valid, 0);
        check("mid_rst_eoc", eoc, 0);
        check("mid_rst_exit_code", exit_code, 0);
        char_q.delete();
        rst = 1'b0;
        access("mid_rst_wdog", 32'h10, 0, 0, 4'hF, WdogResetVal, 0);
        access("mid_rst_level", 32'h04, 0, 0, 4'hF, 32'h0, 0);
        access("mid_rst_exit", 32'h00, 0, 0, 4'hF, 32'h0, 0);

        // Watchdog expiry 5 cycles after the load
        access("wd_ld5", 32'h10, 1, 32'd5, 4'hF, 32'h0, 0);
        repeat (4) @(posedge clk);
        #1;
        check("wd_pre_fired", fired, 0);
        check("wd_pre_eoc", eoc, 0);
        @(posedge clk);
        #1;
        check("wd_fired", fired, 1);
        check("wd_eoc", eoc, 1);
        check("wd_exit_code", exit_code, 31'h7FFF_FFFF);
        access("wd_exit_rd", 32'h00, 0, 0, 4'hF, 32'hFFFF_FFFF, 0);
        access("wd_cnt_rd", 32'h10, 0, 0, 4'hF, 32'd0, 0);
        access("wd_exit_wr", 32'h00, 1, 32'h5, 4'hF, 32'h0, 0);
        access("wd_exit_rd2", 32'h00, 0, 0, 4'hF, 32'hFFFF_FFFF, 0);

        // EXIT write on the expiry edge: software code wins, no fire
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("c_rst_fired", fired, 0);
        access("c_wd_ld3", 32'h10, 1, 32'd3, 4'hF, 32'h0, 0);
        repeat (2) @(posedge clk);
        access("c_exit_wr", 32'h00, 1, 32'h0000_1234, 4'hF, 32'h0, 0);
        check("c_eoc", eoc, 1);
        check("c_exit_code", exit_code, 31'h1234);
        check("c_fired", fired, 0);
        repeat (3) @(posedge clk);
        #1;
        check("c_fired_later", fired, 0);
        access("c_exit_rd", 32'h00, 0, 0, 4'hF, 32'h8000_1234, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout: observed no completion expected completion");
        $fatal(1, "bench time limit");
    end

endmodule
